// File: rtl/fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_feeder
// Description : Captures windowed frames into two ping-pong banks and streams
//               each frame, zero-padded to FFT_SIZE points, over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_feeder #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_SIZE   = 306,
  parameter int FFT_SIZE     = 512,
  parameter int PTR_WIDTH    = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid_i,
  input  logic [PTR_WIDTH-1:0]           wr_ptr_i,
  input  logic signed [SAMPLE_WIDTH-1:0] wr_sample_i,
  input  logic                           wr_done_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic signed [SAMPLE_WIDTH-1:0] out_sample_o,
  output logic [PTR_WIDTH-1:0]           out_index_o,
  output logic                           out_last_o,
  output logic                           overrun_o
);

  // One extra bit so FRAME_SIZE == FFT_SIZE still compares correctly.
  localparam logic [PTR_WIDTH:0]   FRAME_END  = (PTR_WIDTH+1)'(FRAME_SIZE);
  localparam logic [PTR_WIDTH-1:0] LAST_INDEX = PTR_WIDTH'(FFT_SIZE - 1);
  localparam logic [PTR_WIDTH-1:0] ZERO_INDEX = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } rd_state_t;

  rd_state_t rd_state;

  logic signed [SAMPLE_WIDTH-1:0] bank_mem [2][FRAME_SIZE];
  logic [1:0]                     bank_full;
  logic                           wr_bank;
  logic                           rd_bank;
  logic                           frame_accepted;

  logic                 first_write;
  logic                 accept_now;
  logic                 write_en;
  logic                 frame_commit;
  logic                 frame_drop;
  logic                 rd_release;
  logic [PTR_WIDTH-1:0] next_index;
  logic                 next_in_frame;

  // The accept decision is taken on the ptr==0 write and then held for the
  // rest of the frame; a bank being released on the same edge still reads
  // as full here, so that write is rejected.
  assign first_write   = wr_valid_i && (wr_ptr_i == ZERO_INDEX);
  assign accept_now    = first_write ? !bank_full[wr_bank] : frame_accepted;
  assign write_en      = wr_valid_i && accept_now && ({1'b0, wr_ptr_i} < FRAME_END);
  assign frame_commit  = wr_done_i && frame_accepted;
  assign frame_drop    = wr_done_i && !frame_accepted;

  // In STREAM the output is always valid, so ready alone completes a transfer.
  assign rd_release    = (rd_state == STREAM) && out_ready_i && (out_index_o == LAST_INDEX);
  assign next_index    = out_index_o + 1'b1;
  assign next_in_frame = ({1'b0, next_index} < FRAME_END);

  // Sample storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      bank_mem[wr_bank][wr_ptr_i] <= wr_sample_i;
    end
  end

  // Write-side frame tracking: accept latch, bank toggle, overrun pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank        <= 1'b0;
      frame_accepted <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      overrun_o <= frame_drop;
      if (wr_done_i) begin
        frame_accepted <= 1'b0;
        if (frame_accepted) begin
          wr_bank <= !wr_bank;
        end
      end else if (first_write) begin
        frame_accepted <= !bank_full[wr_bank];
      end
    end
  end

  // Bank occupancy: set by the writer on commit, cleared by the reader on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
    end else begin
      if (frame_commit) begin
        bank_full[wr_bank] <= 1'b1;
      end
      if (rd_release) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

  // Reader: prefetch index 0, then stream FFT_SIZE points with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state     <= IDLE;
      rd_bank      <= 1'b0;
      out_valid_o  <= 1'b0;
      out_last_o   <= 1'b0;
      out_index_o  <= '0;
      out_sample_o <= '0;
    end else begin
      case (rd_state)
        IDLE: begin
          if (bank_full[rd_bank]) begin
            rd_state <= FETCH;
          end
        end
        FETCH: begin
          out_valid_o  <= 1'b1;
          out_index_o  <= '0;
          out_last_o   <= 1'b0;
          out_sample_o <= bank_mem[rd_bank][ZERO_INDEX];
          rd_state     <= STREAM;
        end
        STREAM: begin
          if (out_ready_i) begin
            if (out_index_o == LAST_INDEX) begin
              rd_bank <= !rd_bank;
              if (bank_full[!rd_bank]) begin
                // Back-to-back frame: first sample of the other bank follows directly.
                out_index_o  <= '0;
                out_last_o   <= 1'b0;
                out_sample_o <= bank_mem[!rd_bank][ZERO_INDEX];
              end else begin
                out_valid_o  <= 1'b0;
                out_last_o   <= 1'b0;
                out_index_o  <= '0;
                out_sample_o <= '0;
                rd_state     <= IDLE;
              end
            end else begin
              out_index_o  <= next_index;
              out_last_o   <= (next_index == LAST_INDEX);
              out_sample_o <= next_in_frame ? bank_mem[rd_bank][next_index] : '0;
            end
          end
        end
        default: begin
          rd_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_feeder
// Description : Self-checking bench: frame-level model with expected-stream
//               queue plus directed literal checks for each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_feeder;

  localparam int FS  = 306;
  localparam int NFFT = 512;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_valid_i;
  logic [8:0]         wr_ptr_i;
  logic signed [15:0] wr_sample_i;
  logic               wr_done_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic signed [15:0] out_sample_o;
  logic [8:0]         out_index_o;
  logic               out_last_o;
  logic               overrun_o;

  fft_frame_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid_i   (wr_valid_i),
    .wr_ptr_i     (wr_ptr_i),
    .wr_sample_i  (wr_sample_i),
    .wr_done_i    (wr_done_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_sample_o (out_sample_o),
    .out_index_o  (out_index_o),
    .out_last_o   (out_last_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] s;
    logic [8:0]         i;
    logic               l;
    int                 cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t log_q[$];
  int   frame_buf [FS];
  int   checks = 0;
  int   failures = 0;
  int   held = 0;
  bit   acc = 1'b0;
  bit   exp_ov = 1'b0;
  int   ov_count = 0;
  int   cyc = 0;
  int   ready_mode = 0;

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  // Frame-level model: a frame enters the expected stream on commit and
  // occupies storage until its last point is transferred.
  task automatic commit_frame();
    rec_t e;
    for (int i = 0; i < NFFT; i++) begin
      e.s   = (i < FS) ? 16'(frame_buf[i]) : 16'sd0;
      e.i   = 9'(i);
      e.l   = (i == NFFT - 1);
      e.cyc = 0;
      exp_q.push_back(e);
    end
    held++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver
  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1)      out_ready_i = 1'b1;
      else if (ready_mode == 2) out_ready_i = 1'($urandom_range(0, 1));
      else                      out_ready_i = 1'b0;
    end
  end

  // Compare process: mid-cycle sampling of inputs and outputs
  initial begin : monitor
    bit                 prev_rst_low = 1'b0;
    bit                 prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
    logic signed [15:0] prev_s = '0;
    logic [8:0]         prev_i = '0;
    bit                 ov_next;
    rec_t               r, e;
    forever begin
      @(negedge clk);
      if (prev_rst_low) begin
        checks++;
        if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || overrun_o !== 1'b0 ||
            out_index_o !== 9'd0 || out_sample_o !== 16'sd0) begin
          failures++;
          $display("FAIL reset_outputs valid=%b last=%b ovr=%b idx=%0d smp=%0d expected all 0",
                   out_valid_o, out_last_o, overrun_o, out_index_o, out_sample_o);
        end
      end else begin
        checks++;
        if (overrun_o !== exp_ov) begin
          failures++;
          $display("FAIL overrun got=%b expected=%b", overrun_o, exp_ov);
        end
        if (prev_valid && !prev_ready) begin
          checks++;
          if (out_valid_o !== 1'b1 || out_sample_o !== prev_s || out_index_o !== prev_i ||
              out_last_o !== prev_last) begin
            failures++;
            $display("FAIL hold got v=%b s=%0d i=%0d l=%b expected v=1 s=%0d i=%0d l=%b",
                     out_valid_o, out_sample_o, out_index_o, out_last_o, prev_s, prev_i, prev_last);
          end
        end
        if (prev_valid && prev_ready && !prev_last) begin
          checks++;
          if (out_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL valid_drop got=%b expected=1 after idx=%0d", out_valid_o, prev_i);
          end
        end
        if (out_valid_o === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL spurious_valid got idx=%0d expected no valid", out_index_o);
          end
        end
      end
      if (overrun_o === 1'b1) ov_count++;

      if (rst_n === 1'b0) begin
        exp_q.delete();
        held   = 0;
        acc    = 1'b0;
        exp_ov = 1'b0;
      end else begin
        ov_next = 1'b0;
        if (wr_done_i) begin
          if (acc) commit_frame();
          else     ov_next = 1'b1;
          acc = 1'b0;
        end else if (wr_valid_i && wr_ptr_i == 9'd0) begin
          acc = (held < 2);
        end
        if (wr_valid_i && acc && int'(wr_ptr_i) < FS) frame_buf[wr_ptr_i] = int'(wr_sample_i);

        if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
          r.s = out_sample_o; r.i = out_index_o; r.l = out_last_o; r.cyc = cyc;
          log_q.push_back(r);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (r.s !== e.s || r.i !== e.i || r.l !== e.l) begin
              failures++;
              $display("FAIL xfer got s=%0d i=%0d l=%b expected s=%0d i=%0d l=%b",
                       r.s, r.i, r.l, e.s, e.i, e.l);
            end
            if (e.l) held--;
          end
        end
        exp_ov = ov_next;
      end
      prev_rst_low = (rst_n === 1'b0);
      prev_valid   = (out_valid_o === 1'b1);
      prev_ready   = (out_ready_i === 1'b1);
      prev_last    = (out_last_o === 1'b1);
      prev_s       = out_sample_o;
      prev_i       = out_index_o;
    end
  end

  // Writes FS samples off + mul*k, optionally one out-of-frame write, then done.
  task automatic write_frame(input int off, input int mul, input bit stray);
    for (int k = 0; k < FS; k++) begin
      wr_valid_i  = 1'b1;
      wr_ptr_i    = 9'(k);
      wr_sample_i = 16'(off + mul * k);
      @(posedge clk); #1;
    end
    if (stray) begin
      wr_ptr_i    = 9'd400;
      wr_sample_i = 16'sh7777;
      @(posedge clk); #1;
    end
    wr_valid_i = 1'b0;
    wr_done_i  = 1'b1;
    @(posedge clk); #1;
    wr_done_i  = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int bound);
    int c = 0;
    while (log_q.size() < n && c < bound) begin
      @(posedge clk); #1;
      c++;
    end
    chk("xfer_count_timeout", log_q.size(), n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c;
    rst_n = 1'b0; wr_valid_i = 1'b0; wr_ptr_i = '0; wr_sample_i = '0; wr_done_i = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // T1: single frame, ready high, latency and padding
    ready_mode = 1;
    log_q.delete();
    write_frame(0, 1, 1'b1);
    lat = 0;
    while (out_valid_o !== 1'b1 && lat < 20) begin
      @(negedge clk);
      if (out_valid_o !== 1'b1) lat++;
    end
    chk("t1_latency", lat, 2);
    @(posedge clk); #1;
    wait_xfers(NFFT, 700);
    chk("t1_count", log_q.size(), NFFT);
    chk("t1_s0", int'(log_q[0].s), 0);
    chk("t1_s305", int'(log_q[305].s), 305);
    chk("t1_s306_pad", int'(log_q[306].s), 0);
    chk("t1_s400_stray", int'(log_q[400].s), 0);
    chk("t1_last511", int'(log_q[511].l), 1);
    chk("t1_last510", int'(log_q[510].l), 0);
    chk("t1_idx511", int'(log_q[511].i), 511);
    idle(5);
    chk("t1_valid_after", int'(out_valid_o), 0);

    // T2: random backpressure
    ready_mode = 2;
    log_q.delete();
    write_frame(-50, 1, 1'b0);
    wait_xfers(NFFT, 5000);
    chk("t2_count", log_q.size(), NFFT);
    chk("t2_s10", int'(log_q[10].s), -40);
    chk("t2_idx511", int'(log_q[NFFT-1].i), 511);
    ready_mode = 1;
    idle(10);
    chk("t2_count_after", log_q.size(), NFFT);

    // T3: ping-pong, B written while A streams
    log_q.delete();
    write_frame(0, 1, 1'b0);
    c = 0;
    while (log_q.size() < 1 && c < 20) begin @(posedge clk); #1; c++; end
    write_frame(0, -1, 1'b0);
    wait_xfers(2 * NFFT, 1500);
    chk("t3_gap_ok", int'((log_q[512].cyc - log_q[511].cyc) <= 2), 1);
    chk("t3_b_idx0", int'(log_q[512].i), 0);
    chk("t3_b_s1", int'(log_q[513].s), -1);
    chk("t3_b_s305", int'(log_q[817].s), -305);
    idle(10);

    // T4: overrun with ready held low
    ready_mode = 0;
    idle(2);
    log_q.delete();
    ov_count = 0;
    write_frame(1, 1, 1'b0);
    write_frame(2000, 1, 1'b0);
    write_frame(-1, -1, 1'b0);
    idle(3);
    chk("t4_overrun_pulses", ov_count, 1);
    ready_mode = 1;
    wait_xfers(2 * NFFT, 2000);
    idle(600);
    chk("t4_total", log_q.size(), 2 * NFFT);
    chk("t4_a0", int'(log_q[0].s), 1);
    chk("t4_b0", int'(log_q[512].s), 2000);
    chk("t4_b305", int'(log_q[817].s), 2305);

    // T5: reset at index 100
    log_q.delete();
    write_frame(0, 2, 1'b0);
    c = 0;
    while (!(out_valid_o === 1'b1 && out_index_o == 9'd100) && c < 800) begin
      @(posedge clk); #1; c++;
    end
    chk("t5_reached_100", int'(out_index_o), 100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_valid_after_rst", int'(out_valid_o), 0);
    log_q.delete();
    idle(50);
    chk("t5_quiet", log_q.size(), 0);
    write_frame(7, 3, 1'b0);
    wait_xfers(NFFT, 700);
    chk("t5_idx0", int'(log_q[0].i), 0);
    chk("t5_s0", int'(log_q[0].s), 7);
    chk("t5_s305", int'(log_q[305].s), 922);
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
